// File: rtl/pc_pkg.sv
// Shared types and constants for the next-PC unit.
// Optional misaligned-target trapping is enabled by defining PC_TRAP_EN.
package pc_pkg;

    localparam int PC_W = 32;
    localparam logic [PC_W-1:0] TRAP_VEC_DEF = 32'h0000_0080;

    typedef enum logic {
        RUN,
        WAIT_MEM
    } state_t;

    typedef enum logic [2:0] {
        SEL_SEQ,
        SEL_BRANCH,
        SEL_JUMP,
        SEL_REG,
        SEL_MEM
    } sel_t;

    // Result of the priority select: which source won and its raw target.
    typedef struct packed {
        sel_t            sel;
        logic [PC_W-1:0] target;
        logic            chk_align;
        logic            links;
    } tgt_t;

endpackage

// File: rtl/pc_target_mux.sv
// Purely combinational next-PC priority select for the RUN state.
// Alignment handling is left to the caller (PC_TRAP_EN lives in the top).
import pc_pkg::*;

module pc_target_mux (
    input  logic [PC_W-1:0] pc_plus4,
    input  logic            branch,
    input  logic            zero,
    input  logic            jump,
    input  logic            jump_reg,
    input  logic            jump_mem,
    input  logic [15:0]     imm16,
    input  logic [25:0]     jtarget,
    input  logic [PC_W-1:0] rs_val,
    output tgt_t            tgt
);

    logic [PC_W-1:0] br_off;

    // Word offset, sign-extended then scaled to bytes.
    assign br_off = {{(PC_W-18){imm16[15]}}, imm16, 2'b00};

    always_comb begin
        tgt.sel       = SEL_SEQ;
        tgt.target    = pc_plus4;
        tgt.chk_align = 1'b0;
        tgt.links     = 1'b0;
        if (jump_mem) begin
            tgt.sel = SEL_MEM;
        end else if (jump_reg) begin
            tgt.sel       = SEL_REG;
            tgt.target    = rs_val;
            tgt.chk_align = 1'b1;
            tgt.links     = 1'b1;
        end else if (jump) begin
            tgt.sel    = SEL_JUMP;
            tgt.target = {pc_plus4[31:28], jtarget, 2'b00};
            tgt.links  = 1'b1;
        end else if (branch && zero) begin
            tgt.sel       = SEL_BRANCH;
            tgt.target    = pc_plus4 + br_off;
            tgt.chk_align = 1'b1;
        end
    end

endmodule

// File: rtl/next_pc_unit.sv
// PC register and RUN/WAIT_MEM sequencer including jump-through-memory.
// Define PC_TRAP_EN to trap on misaligned targets instead of masking them.
import pc_pkg::*;

module next_pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC = TRAP_VEC_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        branch,
    input  logic        zero,
    input  logic        jump,
    input  logic        jump_reg,
    input  logic        jump_mem,
    input  logic        link_r,
    input  logic [15:0] imm16,
    input  logic [25:0] jtarget,
    input  logic [31:0] rs_val,
    input  logic [31:0] alu_result,
    input  logic [31:0] mem_rdata,
    input  logic        mem_valid,
    output logic [31:0] pc,
    output logic        stall,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic        link_we,
    output logic [31:0] link_addr,
    output logic        trap,
    output logic [31:0] epc
);

`ifdef PC_TRAP_EN
    localparam bit TRAP_ON = 1'b1;
`else
    localparam bit TRAP_ON = 1'b0;
`endif

    state_t          state, state_d;
    logic [PC_W-1:0] pc_d, mem_addr_d, ret, ret_d, pc_plus4;
    logic            link_pend, link_pend_d;
    logic            fault_run, fault_mem;
    tgt_t            tgt;

    assign pc_plus4 = pc + 32'd4;

    pc_target_mux u_mux (
        .pc_plus4 (pc_plus4),
        .branch   (branch),
        .zero     (zero),
        .jump     (jump),
        .jump_reg (jump_reg),
        .jump_mem (jump_mem),
        .imm16    (imm16),
        .jtarget  (jtarget),
        .rs_val   (rs_val),
        .tgt      (tgt)
    );

    assign fault_run = TRAP_ON && tgt.chk_align && (tgt.target[1:0] != 2'b00);
    assign fault_mem = TRAP_ON && (mem_rdata[1:0] != 2'b00);

    always_comb begin
        state_d     = state;
        pc_d        = pc;
        mem_addr_d  = mem_addr;
        link_pend_d = link_pend;
        ret_d       = ret;
        stall       = 1'b0;
        mem_req     = 1'b0;
        link_we     = 1'b0;
        link_addr   = pc_plus4;
        trap        = 1'b0;
        case (state)
            RUN: begin
                if (tgt.sel == SEL_MEM) begin
                    state_d     = WAIT_MEM;
                    mem_addr_d  = alu_result;
                    link_pend_d = link_r;
                    ret_d       = pc_plus4;
                end else if (fault_run) begin
                    pc_d = TRAP_VEC;
                    trap = 1'b1;
                end else begin
                    pc_d    = {tgt.target[31:2], 2'b00};
                    link_we = tgt.links && link_r;
                end
            end
            WAIT_MEM: begin
                stall     = 1'b1;
                mem_req   = 1'b1;
                link_addr = ret;
                if (mem_valid) begin
                    state_d = RUN;
                    if (fault_mem) begin
                        pc_d = TRAP_VEC;
                        trap = 1'b1;
                    end else begin
                        pc_d    = {mem_rdata[31:2], 2'b00};
                        link_we = link_pend;
                    end
                end
            end
            default: state_d = RUN;
        endcase
        // Strobes stay quiet while reset is held, whatever the state says.
        if (reset) begin
            stall   = 1'b0;
            mem_req = 1'b0;
            link_we = 1'b0;
            trap    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= RUN;
            pc        <= RESET_PC;
            mem_addr  <= '0;
            link_pend <= 1'b0;
            ret       <= '0;
        end else begin
            state     <= state_d;
            pc        <= pc_d;
            mem_addr  <= mem_addr_d;
            link_pend <= link_pend_d;
            ret       <= ret_d;
        end
    end

`ifdef PC_TRAP_EN
    logic [PC_W-1:0] epc_q;

    always_ff @(posedge clk) begin
        if (reset)
            epc_q <= '0;
        else if (trap)
            epc_q <= (state == RUN) ? tgt.target : mem_rdata;
    end

    assign epc = epc_q;
`else
    assign epc = '0;
`endif

endmodule

// File: tb/tb_next_pc_unit.sv
// Randomized and directed check of next_pc_unit against a behavioural model.
// Honours PC_TRAP_EN for the expected trap behaviour.
`timescale 1ns/1ps
module tb_next_pc_unit;

`ifdef PC_TRAP_EN
    localparam bit TRAP_ON = 1'b1;
`else
    localparam bit TRAP_ON = 1'b0;
`endif
    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] TVEC   = 32'h0000_0080;

    logic        clk = 1'b0;
    logic        reset, branch, zero, jump, jump_reg, jump_mem, link_r, mem_valid;
    logic [15:0] imm16;
    logic [25:0] jtarget;
    logic [31:0] rs_val, alu_result, mem_rdata;
    logic [31:0] pc, mem_addr, link_addr, epc;
    logic        stall, mem_req, link_we, trap;

    always #5 clk = ~clk;

    next_pc_unit #(.RESET_PC(RST_PC), .TRAP_VEC(TVEC)) dut (
        .clk(clk), .reset(reset), .branch(branch), .zero(zero), .jump(jump),
        .jump_reg(jump_reg), .jump_mem(jump_mem), .link_r(link_r),
        .imm16(imm16), .jtarget(jtarget), .rs_val(rs_val),
        .alu_result(alu_result), .mem_rdata(mem_rdata), .mem_valid(mem_valid),
        .pc(pc), .stall(stall), .mem_req(mem_req), .mem_addr(mem_addr),
        .link_we(link_we), .link_addr(link_addr), .trap(trap), .epc(epc)
    );

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Architectural view: where the PC is, and whether a memory jump is outstanding.
    logic [31:0] m_pc, m_addr, m_ret, m_epc;
    bit          m_wait, m_lp, m_known = 0;

    task automatic cyc(input bit r, input bit b, input bit z, input bit j, input bit jr,
                       input bit jm, input bit lr, input logic [15:0] im,
                       input logic [25:0] jt, input logic [31:0] rv,
                       input logic [31:0] ar, input logic [31:0] md, input bit mv);
        logic [31:0] p4, tgt;
        bit commit, chk_al, lnk, fault, e_lwe, e_trap;
        reset = r; branch = b; zero = z; jump = j; jump_reg = jr; jump_mem = jm;
        link_r = lr; imm16 = im; jtarget = jt; rs_val = rv; alu_result = ar;
        mem_rdata = md; mem_valid = mv;
        #2;
        p4 = m_pc + 32'd4; tgt = p4; chk_al = 0; lnk = 0;
        if (!m_wait) begin
            commit = !jm;
            if (jm)            ;
            else if (jr)       begin tgt = rv; chk_al = 1; lnk = lr; end
            else if (j)        begin tgt = {p4[31:28], jt, 2'b00}; lnk = lr; end
            else if (b && z)   begin tgt = p4 + 32'($signed(im) * 4); chk_al = 1; end
        end else begin
            commit = mv; tgt = md; chk_al = 1; lnk = m_lp;
        end
        fault  = TRAP_ON && commit && chk_al && (tgt % 4 != 0);
        e_lwe  = !r && commit && lnk && !fault;
        e_trap = !r && fault;
        if (m_known) begin
            chk("pc", pc, m_pc);
            chk("stall", 32'(stall), 32'(!r && m_wait));
            chk("mem_req", 32'(mem_req), 32'(!r && m_wait));
            chk("mem_addr", mem_addr, m_addr);
            chk("link_we", 32'(link_we), 32'(e_lwe));
            if (e_lwe) chk("link_addr", link_addr, m_wait ? m_ret : p4);
            chk("trap", 32'(trap), 32'(e_trap));
            chk("epc", epc, m_epc);
        end
        @(posedge clk);
        if (r) begin
            m_pc = RST_PC; m_wait = 0; m_addr = 0; m_lp = 0; m_ret = 0; m_epc = 0;
            m_known = 1;
        end else if (!m_wait && jm) begin
            m_wait = 1; m_addr = ar; m_lp = lr; m_ret = p4;
        end else if (commit) begin
            m_wait = 0;
            if (fault) begin m_pc = TVEC; m_epc = tgt; end
            else m_pc = tgt & ~32'd3;
        end
        @(negedge clk);
    endtask

    task automatic idle(input bit r = 0);
        cyc(r, 0, 0, 0, 0, 0, 0, 16'h0, 26'h0, 32'h0, 32'h0, 32'h0, 0);
    endtask

    task automatic jr_to(input logic [31:0] a, input bit lr = 0);
        cyc(0, 0, 0, 0, 1, 0, lr, 16'h0, 26'h0, a, 32'h0, 32'h0, 0);
    endtask

    task automatic mem_wait(input logic [31:0] md, input bit mv);
        cyc(0, 1, 1, 1, 1, 1, 1, 16'h1234, 26'h3ff_ffff, 32'hdead_beec,
            32'h5555_5554, md, mv);
    endtask

    initial begin
        @(negedge clk);
        idle(1);
        // Idle run from reset.
        idle(0); idle(0); idle(0);
        chk("pc_idle3", pc, 32'd12);
        chk("stall_idle", 32'(stall), 32'd0);
        // Backward branch, then a not-taken one.
        jr_to(32'h100);
        cyc(0, 1, 1, 0, 0, 0, 0, 16'hFFFE, 26'h0, 32'h0, 32'h0, 32'h0, 0);
        chk("br_taken", pc, 32'h0FC);
        jr_to(32'h100);
        cyc(0, 1, 0, 0, 0, 0, 0, 16'hFFFE, 26'h0, 32'h0, 32'h0, 32'h0, 0);
        chk("br_not_taken", pc, 32'h104);
        // imm16 = -1 lands back on the same PC.
        cyc(0, 1, 1, 0, 0, 0, 0, 16'hFFFF, 26'h0, 32'h0, 32'h0, 32'h0, 0);
        chk("br_minus1", pc, 32'h104);
        // Linked register jump.
        jr_to(32'h200);
        jr_to(32'h400, 1);
        chk("jr_link_pc", pc, 32'h400);
        idle(0);
        // Jump through memory with three stall cycles.
        jr_to(32'h300);
        cyc(0, 0, 0, 0, 0, 1, 1, 16'h0, 26'h0, 32'h0, 32'h1000, 32'h0, 1);
        chk("jmor_stall", 32'(stall), 32'd1);
        chk("jmor_addr", mem_addr, 32'h1000);
        mem_wait(32'h0, 0); mem_wait(32'h0, 0); mem_wait(32'h800, 1);
        chk("jmor_pc", pc, 32'h800);
        idle(0);
        // Wrap-around of the sequential add.
        jr_to(32'hFFFF_FFFC);
        idle(0);
        chk("pc_wrap", pc, 32'h0);
        // Reset abandons an outstanding memory jump.
        cyc(0, 0, 0, 0, 0, 1, 1, 16'h0, 26'h0, 32'h0, 32'h2000, 32'h0, 0);
        mem_wait(32'h0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 16'h0, 26'h0, 32'h0, 32'h0, 32'h900, 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 16'h0, 26'h0, 32'h0, 32'h0, 32'h900, 1);
        chk("rst_wait_pc", pc, RST_PC + 32'd4);
        // Misaligned register target.
        jr_to(32'h402, 1);
        chk("jr_misalign", pc, TRAP_ON ? TVEC : 32'h400);
        chk("epc_misalign", epc, TRAP_ON ? 32'h402 : 32'h0);
        idle(0);
        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            bit jm_r, r_r;
            jm_r = ($urandom_range(0, 7) == 0);
            r_r  = ($urandom_range(0, 49) == 0);
            cyc(r_r, 1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0),
                1'($urandom_range(0, 4) == 0), jm_r, 1'($urandom),
                16'($urandom), 26'($urandom), $urandom, $urandom, $urandom,
                ($urandom_range(0, 2) == 0));
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/next_pc_unit.md
NEXT_PC_UNIT -- requirements
Module: next_pc_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the PC value loaded on reset.
REQ-002 SHALL have parameter TRAP_VEC, default 32'h0000_0080, the trap target used only with PC_TRAP_EN.
REQ-003 SHALL have a single clock and a synchronous, active-high reset:
- clk  in  1  rising-edge clock for all state.
- reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have the following control and data inputs:
- branch  in  1  conditional branch decoded this cycle.
- zero  in  1  ALU zero flag.
- jump  in  1  J/JAL decoded.
- jump_reg  in  1  jr/jalr: target from register.
- jump_mem  in  1  jump through memory (jmor): target read from data memory.
- link_r  in  1  the current jump writes its return address.
- imm16  in  16  branch offset in words.
- jtarget  in  26  J-format target field.
- rs_val  in  32  register target.
- alu_result  in  32  memory address of the jmor target.
- mem_rdata  in  32  memory read data.
- mem_valid  in  1  mem_rdata valid this cycle.
REQ-005 SHALL have the following outputs:
- pc  out  32  current PC.
- stall  out  1  hold upstream fetch/decode.
- mem_req  out  1  jmor target read request.
- mem_addr  out  32  jmor target read address.
- link_we  out  1  one-cycle return-address write strobe.
- link_addr  out  32  return address.
- trap  out  1  one-cycle misaligned-target pulse.
- epc  out  32  faulting target.

Function
REQ-006 SHALL be a two-state FSM, RUN and WAIT_MEM.
REQ-007 In RUN, SHALL select the next PC by this priority:
- jump_mem: go to WAIT_MEM, hold pc, latch mem_addr<=alu_result, latch link_pend<=link_r and ret<=pc+4.
- jump_reg: pc<=rs_val.
- jump: pc<={pc_plus4[31:28],jtarget,2'b00}.
- branch&zero: pc<=pc+4+(sext(imm16)<<2).
- otherwise: pc<=pc+4.
REQ-008 In WAIT_MEM, SHALL assert stall=1 and mem_req=1 with mem_addr stable, and hold pc.
REQ-009 In WAIT_MEM, SHALL ignore all control inputs.
REQ-010 On mem_valid in WAIT_MEM, SHALL set pc<=mem_rdata, pulse link_we=link_pend with link_addr=ret, and return to RUN; a jmor therefore costs ≥1 stall cycle.
REQ-011 SHALL ignore mem_valid while in RUN.
REQ-012 SHALL keep stall=0 and mem_req=0 in RUN.
REQ-013 For jump_reg or jump with link_r=1, SHALL drive link_we=1 and link_addr=pc+4 for exactly the commit cycle.
REQ-014 SHALL never assert link_we when link_r=0.
REQ-015 SHALL compute all adds modulo 2^32: pc=32'hFFFF_FFFC with no jump gives pc=0.
REQ-016 SHALL compute branch offsets as signed values; imm16=16'hFFFF moves the PC to pc+0.
REQ-017 SHALL not register any output other than pc, state, mem_addr, epc, link_pend and ret; link_we, link_addr and trap are combinational from state and inputs.

Reset
REQ-018 On reset=1 at a clock edge, SHALL set pc=RESET_PC, state=RUN, link_pend=0, epc=0, mem_addr=0 and ret=0.
REQ-019 During and after reset, SHALL hold stall=0, mem_req=0, link_we=0 and trap=0.
REQ-020 Reset SHALL override everything, including reset asserted mid-WAIT_MEM: the pending jmor is abandoned, no link write occurs, and a later mem_valid is ignored.

Configuration
REQ-021 With macro PC_TRAP_EN defined, a selected target (jump_reg, jump_mem data or branch) with bits[1:0]!=0 SHALL set pc<=TRAP_VEC, epc<=the faulting target and pulse trap=1 for one cycle, with no link write.
REQ-022 Without PC_TRAP_EN, target bits[1:0] SHALL be forced to 00, trap SHALL be tied to 0 and epc SHALL be tied to 0.

Structure
REQ-023 Package pc_pkg SHALL hold the FSM state enum (RUN, WAIT_MEM), the PC width constant (32) and the default TRAP_VEC constant.
REQ-024 Sub-module pc_target_mux SHALL be the purely combinational priority selection of REQ-007; the FSM and registers SHALL stay in next_pc_unit.

Verification
REQ-025 Reset, then 3 idle cycles -> pc=0, 4, 8, 12; stall=0.
REQ-026 At pc=0x100: branch=1, zero=1, imm16=0xFFFE -> next pc=0xFC; with zero=0 -> pc=0x104.
REQ-027 At pc=0x200: jump_reg=1, link_r=1, rs_val=0x400 -> pc=0x400 and link_we=1 with link_addr=0x204 for exactly one cycle.
REQ-028 At pc=0x300: jump_mem=1, link_r=1, alu_result=0x1000, mem_valid after 3 cycles with 0x800 -> stall=1 and mem_req=1 with mem_addr=0x1000 for 3 cycles; then pc=0x800, link_we=1, link_addr=0x304.
REQ-029 Reset during WAIT_MEM, then mem_valid=1 -> pc=RESET_PC, no link_we, state=RUN.
REQ-030 With PC_TRAP_EN: jump_reg with rs_val=0x402 -> pc=0x80, epc=0x402, trap=1 for one cycle; without the macro -> pc=0x400.
